mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the 3-stage RISC-V core.
- Serialises requests with one outstanding transaction at a time.
- Routes the response back to the owning requester.
- Drives a pipeline stall while any request is pending.
- Sits between the core's fetch/stage-3 memory logic and the memory model/controller.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width
STARVE_LIMIT, 4, max consecutive D grants while I is waiting; then I is granted
TIMEOUT, 15, response-wait cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request, level; held until i_done
i_addr  in  ADDR_WIDTH  fetch address
i_done  out  1  1-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_WIDTH  fetch data
d_req  in  1  data request, level; held until d_done
d_we  in  4  byte write mask; 0 = load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_done  out  1  1-cycle pulse: load data valid / store acknowledged
d_rdata  out  DATA_WIDTH  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  registered request address
mem_we  out  4  registered byte write mask
mem_wdata  out  DATA_WIDTH  registered write data
mem_resp_valid  in  1  read data valid / write acknowledge
mem_rdata  in  DATA_WIDTH  read data
stall  out  1  core stall
err  out  1  timeout error pulse (0 without the optional feature)

Behaviour:
Reset (asynchronous):
- All outputs 0; state IDLE; owner I; starve counter 0.
- Any in-flight transaction is abandoned.
- A mem_resp_valid arriving after reset is ignored.

State IDLE:
- If d_req and not (i_req and starve_cnt == STARVE_LIMIT): grant D.
- Else if i_req: grant I.
- On grant: register addr/we/wdata (I grant forces we = 0), record owner, go to REQ.

State REQ:
- mem_req_valid = 1; mem_addr/mem_we/mem_wdata are stable from the registers.
- On mem_req_ready, go to WAIT.

State WAIT:
- On mem_resp_valid: pulse the owner's done for that cycle; route mem_rdata combinationally to i_rdata/d_rdata; go to IDLE.
- A mem_resp_valid seen in IDLE or REQ is a protocol violation and is ignored.

Latency and requester rules:
- Minimum request-to-done latency is 3 cycles: grant at cycle 0, ready at cycle 1, response at cycle 2.
- One dead IDLE cycle follows every completion; no back-to-back grant in the done cycle.
- If a requester still holds req in the cycle after its done, that is a new request.

Starvation counter (starve_cnt), updated at each grant:
- D granted while i_req is high: increment, saturating at STARVE_LIMIT.
- I granted, or D granted while i_req is low: clear to 0.

Simultaneous requests in IDLE: D wins unless the starve limit is reached.

stall = (i_req & ~i_done) | (d_req & ~d_done). It is combinational and drops in the done cycle.

Requester inputs are sampled only at grant; changes after grant have no effect on the transaction in flight.

Optional Feature:
ARB_RESP_TIMEOUT_EN
- Defined: a 4-bit-minimum counter starts on entry to WAIT and resets on leaving it. If TIMEOUT cycles elapse with no mem_resp_valid:
  - err pulses 1 cycle;
  - the owner's done pulses the same cycle with rdata = 0;
  - state returns to IDLE, so the core never deadlocks.
- Not defined: no counter, WAIT holds indefinitely, err tied to 0.

Test Plan:
1. Reset, then i_req=1, i_addr=0x100, memory ready immediately, response next cycle with 0xDEADBEEF -> mem_req_valid at cycle 1 with mem_addr=0x100, mem_we=0; i_done at cycle 2 with i_rdata=0xDEADBEEF; stall high cycles 0-1, low at cycle 2.
2. i_req and d_req (store, d_we=4'hF, d_addr=0x200, d_wdata=0x12345678) both rising in the same cycle -> D granted first, mem_we=4'hF, mem_wdata=0x12345678; I granted in the IDLE cycle after d_done.
3. i_req held with d_req re-asserted continuously -> exactly 4 D grants, then I granted on the 5th, then D again; starve_cnt=0 after the I grant.
4. mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr stable throughout, stall high; a stray mem_resp_valid pulse during REQ produces no done.
5. rst asserted asynchronously mid-WAIT, then mem_resp_valid arrives after release -> all outputs 0 immediately; no i_done/d_done generated; next request proceeds normally.
6. With ARB_RESP_TIMEOUT_EN and TIMEOUT=15, d_req load with no memory response -> err and d_done pulse together 15 cycles after entering WAIT, d_rdata=0, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between the instruction
// fetch requester (I) and the load/store requester (D). Only one transaction
// is outstanding at a time. The response is routed back to the requester that
// owns the transaction, and the core is stalled while any request is pending.
// Optional feature macro: ARB_RESP_TIMEOUT_EN. When it is defined, a WAIT
// state that receives no response for TIMEOUT cycles completes with err=1
// and rdata=0.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [3:0]            d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state;
  logic          owner_d;     // 1 = D owns the transaction, 0 = I
  logic [SW-1:0] starve_cnt;
  logic          grant_d;
  logic          grant_i;
  logic          resp_fire;
  logic          to_hit;
  logic          done_evt;

`ifdef ARB_RESP_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Count cycles spent in WAIT; the count restarts whenever WAIT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT && !done_evt) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Timeout fires on the TIMEOUT-th cycle after entry to WAIT, but only if no
  // response arrives in that cycle.
  assign to_hit = (state == ST_WAIT) && !mem_resp_valid && (to_cnt == TW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign to_hit         = 1'b0;
`endif

  // D wins arbitration unless I has been passed over STARVE_LIMIT times in a row.
  assign grant_d = (state == ST_IDLE) && d_req &&
                   !(i_req && (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant_i = (state == ST_IDLE) && !grant_d && i_req;

  // A response counts only in WAIT; strays in IDLE/REQ are ignored.
  assign resp_fire = (state == ST_WAIT) && mem_resp_valid;
  assign done_evt  = resp_fire || to_hit;

  // Completion pulses and combinational read-data routing to the owner.
  always_comb begin
    i_done  = done_evt && !owner_d;
    d_done  = done_evt && owner_d;
    i_rdata = '0;
    d_rdata = '0;
    if (resp_fire && !owner_d) i_rdata = mem_rdata;
    if (resp_fire && owner_d)  d_rdata = mem_rdata;
  end

  assign mem_req_valid = (state == ST_REQ);
  assign err           = to_hit;
  assign stall         = (i_req && !i_done) || (d_req && !d_done);

  // Arbitration FSM, request registers and the starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            state     <= ST_REQ;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_i) begin
            owner_d    <= 1'b0;
            mem_addr   <= i_addr;
            mem_we     <= 4'h0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_evt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
// Define ARB_RESP_TIMEOUT_EN for both files to include the timeout scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  logic        cap_i, cap_d;
  logic [31:0] cap_addr, cap_wdata, cap_irdata, cap_drdata;
  logic [3:0]  cap_we;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request to memory, accept it at once, answer the next cycle
  // with rdata, and capture what the arbiter issued and whom it answered.
  task automatic serve(input logic [31:0] rdata);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("serve_wait", 32'd0, 32'd1);
    cap_addr  = mem_addr;
    cap_we    = mem_we;
    cap_wdata = mem_wdata;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    #1;
    cap_i      = i_done;
    cap_d      = d_done;
    cap_irdata = i_rdata;
    cap_drdata = d_rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  logic exp_own [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    #1;
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: single fetch with minimum latency
    i_req = 1; i_addr = 32'h100; mem_req_ready = 1;
    #1;
    chk("t1_c0_stall", 32'(stall), 32'd1);
    chk("t1_c0_valid", 32'(mem_req_valid), 32'd0);
    tick();
    chk("t1_c1_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_c1_addr", mem_addr, 32'h100);
    chk("t1_c1_we", 32'(mem_we), 32'd0);
    chk("t1_c1_stall", 32'(stall), 32'd1);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_c2_idone", 32'(i_done), 32'd1);
    chk("t1_c2_irdata", i_rdata, 32'hDEADBEEF);
    chk("t1_c2_ddone", 32'(d_done), 32'd0);
    chk("t1_c2_stall", 32'(stall), 32'd0);
    tick();
    i_req = 0; mem_resp_valid = 0; mem_rdata = 0;
    tick();

    // 2: simultaneous requests, D store first, then I after a dead cycle
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 4'hF; d_addr = 32'h200; d_wdata = 32'h12345678;
    serve(32'hAAAA0001);
    d_req = 0;
    chk("t2_d_done", 32'(cap_d), 32'd1);
    chk("t2_d_notI", 32'(cap_i), 32'd0);
    chk("t2_d_addr", cap_addr, 32'h200);
    chk("t2_d_we", 32'(cap_we), 32'hF);
    chk("t2_d_wdata", cap_wdata, 32'h12345678);
    #1;
    chk("t2_dead_cycle", 32'(mem_req_valid), 32'd0);
    serve(32'h0BADF00D);
    i_req = 0;
    chk("t2_i_done", 32'(cap_i), 32'd1);
    chk("t2_i_addr", cap_addr, 32'h104);
    chk("t2_i_we", 32'(cap_we), 32'd0);
    chk("t2_i_rdata", cap_irdata, 32'h0BADF00D);
    tick();

    // 3: starvation limit, four D grants then I, then D again
    i_req = 1; i_addr = 32'h180;
    d_req = 1; d_we = 4'h0; d_addr = 32'h240;
    for (int k = 0; k < 6; k++) begin
      serve(32'h1000 + 32'(k));
      chk($sformatf("t3_owner%0d", k), 32'(cap_d), 32'(exp_own[k]));
      chk($sformatf("t3_done%0d", k), 32'(cap_i ^ cap_d), 32'd1);
    end
    i_req = 0; d_req = 0;
    tick();

    // 4: memory not ready for 5 cycles, stray response in REQ ignored
    d_req = 1; d_we = 4'h0; d_addr = 32'h300;
    tick();
    d_addr = 32'h999;
    for (int k = 0; k < 5; k++) begin
      mem_resp_valid = (k == 2);
      #1;
      chk($sformatf("t4_valid%0d", k), 32'(mem_req_valid), 32'd1);
      chk($sformatf("t4_addr%0d", k), mem_addr, 32'h300);
      chk($sformatf("t4_stall%0d", k), 32'(stall), 32'd1);
      chk($sformatf("t4_nodone%0d", k), 32'(d_done | i_done), 32'd0);
      tick();
    end
    mem_resp_valid = 0;
    serve(32'hCAFE0004);
    d_req = 0;
    chk("t4_done", 32'(cap_d), 32'd1);
    chk("t4_rdata", cap_drdata, 32'hCAFE0004);
    tick();

    // 5: asynchronous reset mid-WAIT, late response ignored
    i_req = 1; i_addr = 32'h400; mem_req_ready = 1;
    tick();
    tick();
    mem_req_ready = 0;
    #2;
    rst = 1; i_req = 0;
    #1;
    chk("t5_valid", 32'(mem_req_valid), 32'd0);
    chk("t5_addr", mem_addr, 32'h0);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_idone", 32'(i_done), 32'd0);
    tick();
    rst = 0;
    tick();
    mem_resp_valid = 1; mem_rdata = 32'h55555555;
    #1;
    chk("t5_stray_done", 32'(i_done | d_done), 32'd0);
    tick();
    mem_resp_valid = 0;
    i_req = 1; i_addr = 32'h500;
    serve(32'h600DD00D);
    i_req = 0;
    chk("t5_after_done", 32'(cap_i), 32'd1);
    chk("t5_after_addr", cap_addr, 32'h500);
    chk("t5_after_rdata", cap_irdata, 32'h600DD00D);
    tick();

`ifdef ARB_RESP_TIMEOUT_EN
    // 6: D load with no response times out after 15 WAIT cycles
    d_req = 1; d_we = 4'h0; d_addr = 32'h700; mem_req_ready = 1;
    tick();
    tick();
    mem_req_ready = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("t6_noerr%0d", k), 32'(err | d_done), 32'd0);
      tick();
    end
    #1;
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_ddone", 32'(d_done), 32'd1);
    chk("t6_rdata", d_rdata, 32'h0);
    d_req = 0;
    tick();
    chk("t6_idle_err", 32'(err), 32'd0);
    chk("t6_idle_valid", 32'(mem_req_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
